// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit DEPTH-stage delay line with per-stage valid, stall, flush and occupancy count
module dff_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       din_valid,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int OW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  if (DEPTH < 1) begin : g_chk
    $error("dff_pipe: DEPTH must be >= 1");
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= RST_VAL;
      v <= '0;
      occupancy <= '0;
    end else if (flush) begin
      v <= '0;
      occupancy <= '0;
    end else if (en) begin
      d[0] <= din;
      v[0] <= din_valid;
      for (int i = 1; i < DEPTH; i++) begin
        d[i] <= d[i-1];
        v[i] <= v[i-1];
      end
      occupancy <= occupancy + OW'(din_valid) - OW'(v[DEPTH-1]);
    end
  assign dout = d[DEPTH-1];
  assign dout_valid = v[DEPTH-1];
endmodule
